// File: rtl/aes_pkg.sv
// Shared AES key-schedule types, constants and GF(2^8) helper.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_EXPAND,
        ST_DONE
    } state_e;

    typedef logic [31:0] word_t;

    localparam int         NUM_RK_128 = 11;
    localparam int         NUM_RK_256 = 15;
    localparam logic [7:0] RCON_INIT  = 8'h01;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // x^254 = x^2 * x^4 * ... * x^128; zero maps to zero as AES requires
    always_comb begin
        sq  = in_i;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128/256 key schedule feeding the round-key memory, one key per cycle.
// Optional KEYEXP_ABORT_EN adds an abort input that cancels a run and clears the memory.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int NK_MAX     = 8,
    parameter int NUM_RK_MAX = 15
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    input  logic                          key_256_i,
    input  logic [32*NK_MAX-1:0]          key_i,
`ifdef KEYEXP_ABORT_EN
    input  logic                          abort_i,
`endif
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          reset_valid_bits_o,
    output logic                          w_en_o,
    output logic [$clog2(NUM_RK_MAX)-1:0] waddr_o,
    output logic [127:0]                  wkey_o
);

    localparam int AW = $clog2(NUM_RK_MAX);

    state_e         state_q, state_d;
    logic [127:0]   ka_q, ka_d, kb_q, kb_d;
    logic           is256_q, is256_d;
    logic [7:0]     rcon_q, rcon_d;
    logic [AW-1:0]  nidx_q, nidx_d;
    logic           abrt_q, abrt_d;

    logic           busy_q, busy_d, done_q, done_d, rvb_q, rvb_d, wen_q, wen_d;
    logic [AW-1:0]  waddr_q, waddr_d;
    logic [127:0]   wkey_q, wkey_d;

    logic           abort_w;
    logic           use_rcon, load_kb, fin;
    word_t          tsrc, sub_in, sub_out, t, n0, n1, n2, n3;
    logic [127:0]   nkey;

`ifdef KEYEXP_ABORT_EN
    assign abort_w = abort_i;
`else
    assign abort_w = 1'b0;
`endif

    // nidx_q is the index of the key being prepared for the next cycle's write
    assign use_rcon = !is256_q || !nidx_q[0];
    assign load_kb  = is256_q && (nidx_q == AW'(1));
    assign fin      = nidx_q == (is256_q ? AW'(NUM_RK_256) : AW'(NUM_RK_128));

    assign tsrc   = is256_q ? kb_q[31:0] : ka_q[31:0];
    assign sub_in = use_rcon ? {tsrc[23:0], tsrc[31:24]} : tsrc;

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (.in_i(sub_in[8*i +: 8]), .out_o(sub_out[8*i +: 8]));
    end

    assign t    = sub_out ^ (use_rcon ? {rcon_q, 24'h0} : 32'h0);
    assign n0   = ka_q[127:96] ^ t;
    assign n1   = ka_q[95:64]  ^ n0;
    assign n2   = ka_q[63:32]  ^ n1;
    assign n3   = ka_q[31:0]   ^ n2;
    assign nkey = {n0, n1, n2, n3};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start_i) state_d = ST_CLEAR;
            ST_CLEAR:  state_d = abrt_q ? ST_IDLE : ST_LOAD;
            ST_LOAD:   state_d = abort_w ? ST_CLEAR : (load_kb ? ST_LOAD : ST_EXPAND);
            ST_EXPAND: state_d = abort_w ? ST_CLEAR : (fin ? ST_DONE : ST_EXPAND);
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Registered outputs are computed one cycle ahead, for the state being entered
    always_comb begin
        ka_d    = ka_q;
        kb_d    = kb_q;
        is256_d = is256_q;
        rcon_d  = rcon_q;
        nidx_d  = nidx_q;
        abrt_d  = abrt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        rvb_d   = 1'b0;
        wen_d   = 1'b0;
        waddr_d = '0;
        wkey_d  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    {ka_d, kb_d} = key_i[255:0];
                    is256_d      = key_256_i;
                    rcon_d       = RCON_INIT;
                    nidx_d       = '0;
                    abrt_d       = 1'b0;
                    rvb_d        = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (abrt_q) begin
                    abrt_d = 1'b0;
                end else begin
                    busy_d  = 1'b1;
                    wen_d   = 1'b1;
                    wkey_d  = ka_q;
                    nidx_d  = AW'(1);
                end
            end
            ST_LOAD, ST_EXPAND: begin
                if (abort_w) begin
                    abrt_d = 1'b1;
                    rvb_d  = 1'b1;
                    busy_d = 1'b1;
                end else if (state_q == ST_LOAD && load_kb) begin
                    busy_d  = 1'b1;
                    wen_d   = 1'b1;
                    waddr_d = nidx_q;
                    wkey_d  = kb_q;
                    nidx_d  = nidx_q + AW'(1);
                end else if (state_q == ST_EXPAND && fin) begin
                    done_d = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                    wen_d   = 1'b1;
                    waddr_d = nidx_q;
                    wkey_d  = nkey;
                    nidx_d  = nidx_q + AW'(1);
                    if (use_rcon) rcon_d = xtime(rcon_q);
                    if (is256_q) begin
                        ka_d = kb_q;
                        kb_d = nkey;
                    end else begin
                        ka_d = nkey;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ka_q    <= '0;
            kb_q    <= '0;
            is256_q <= 1'b0;
            rcon_q  <= '0;
            nidx_q  <= '0;
            abrt_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rvb_q   <= 1'b0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wkey_q  <= '0;
        end else begin
            ka_q    <= ka_d;
            kb_q    <= kb_d;
            is256_q <= is256_d;
            rcon_q  <= rcon_d;
            nidx_q  <= nidx_d;
            abrt_q  <= abrt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rvb_q   <= rvb_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wkey_q  <= wkey_d;
        end
    end

    // Abort must kill the write already sitting in the output register
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign reset_valid_bits_o = rvb_q;
    assign w_en_o             = wen_q & ~abort_w;
    assign waddr_o            = w_en_o ? waddr_q : '0;
    assign wkey_o             = w_en_o ? wkey_q : '0;

endmodule

// File: tb/tb_aes_key_expander.sv
// Randomised self-checking bench: cycle-exact output trace against a FIPS-197 word-array model.
module tb_aes_key_expander;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         key_256;
    logic [255:0] key_in;
    logic         busy, done, rvb, w_en;
    logic [3:0]   waddr;
    logic [127:0] wkey;
`ifdef KEYEXP_ABORT_EN
    logic         abort;
`endif

    always #5 clk = ~clk;

    aes_key_expander dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .start_i            (start),
        .key_256_i          (key_256),
        .key_i              (key_in),
`ifdef KEYEXP_ABORT_EN
        .abort_i            (abort),
`endif
        .busy_o             (busy),
        .done_o             (done),
        .reset_valid_bits_o (rvb),
        .w_en_o             (w_en),
        .waddr_o            (waddr),
        .wkey_o             (wkey)
    );

    int           checks = 0;
    int           errors = 0;
    logic [7:0]   sbox [256];
    logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [127:0] exp_rk [15];
    logic [127:0] cap [16];
    int           nr;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int s);
        return (x << s) | (x >> (8 - s));
    endfunction

    // S-box generated by walking the multiplicative group with generator 3
    task automatic build_sbox();
        logic [7:0] p, q;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            sbox[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
    endfunction

    task automatic model(input logic [255:0] key, input logic k256);
        logic [31:0] w [60];
        logic [31:0] tmp;
        int          nk;
        nk = k256 ? 8 : 4;
        nr = k256 ? 15 : 11;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*nr; i++) begin
            tmp = w[i-1];
            if (i % nk == 0) tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rcon_tab[i/nk - 1], 24'h0};
            else if (nk == 8 && i % nk == 4) tmp = subw(tmp);
            w[i] = w[i-nk] ^ tmp;
        end
        for (int r = 0; r < nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [255:0] observe();
        return {120'd0, busy, done, rvb, w_en, waddr, wkey};
    endfunction

    // Cycle c counts from the edge that sampled start (cycle 0)
    function automatic logic [255:0] expect_at(input int c);
        logic [3:0]   a;
        logic [127:0] k;
        logic         wen_e;
        wen_e = (c >= 2) && (c <= nr + 1);
        a = '0;
        k = '0;
        if (wen_e) begin
            a = 4'(c - 2);
            k = exp_rk[c - 2];
        end
        return {120'd0, (c >= 1 && c <= nr + 1), (c == nr + 2), (c == 1), wen_e, a, k};
    endfunction

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run(input logic [255:0] key, input logic k256, input bit restart,
                       input int rst_at, input int abort_at);
        logic [255:0] e;
        model(key, k256);
        foreach (cap[i]) cap[i] = '0;
        @(negedge clk);
        key_in  = key;
        key_256 = k256;
        start   = 1'b1;
        for (int c = 1; c <= nr + 2; c++) begin
            @(negedge clk);
            start   = restart && (c == 3 || c == 8);
            key_in  = rnd256();
            key_256 = 1'($urandom);
            e = expect_at(c);
            if (abort_at != 0 && c == abort_at)     e = {120'd0, 4'b1000, 132'd0};
            if (abort_at != 0 && c == abort_at + 1) e = {120'd0, 4'b1010, 132'd0};
            if (abort_at != 0 && c >  abort_at + 1) e = '0;
            check($sformatf("k%0d_cyc%0d", k256 ? 256 : 128, c), observe(), e);
            if (w_en) cap[waddr] = wkey;
            if (c == rst_at) begin
                start = 1'b0;
                #2 rst_n = 1'b0;
                #1 check("async_rst", observe(), '0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
`ifdef KEYEXP_ABORT_EN
            if (abort_at != 0 && (c == abort_at - 1 || c == abort_at)) begin
                @(posedge clk);
                #1 abort = (c == abort_at - 1);
            end
`endif
        end
        start = 1'b0;
    endtask

    initial begin
        build_sbox();
        rst_n   = 1'b0;
        start   = 1'b0;
        key_256 = 1'b0;
        key_in  = '0;
`ifdef KEYEXP_ABORT_EN
        abort   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset_state", observe(), '0);
        rst_n = 1'b1;

        run({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0, 1'b0, 0, 0);
        check("fips128_rk1",  {128'd0, cap[1]},  {128'd0, 128'ha0fafe1788542cb123a339392a6c7605});
        check("fips128_rk10", {128'd0, cap[10]}, {128'd0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});

        run(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 1'b1, 1'b0, 0, 0);
        check("fips256_rk0",  {128'd0, cap[0]},  {128'd0, 128'h603deb1015ca71be2b73aef0857d7781});
        check("fips256_rk1",  {128'd0, cap[1]},  {128'd0, 128'h1f352c073b6108d72d9810a30914dff4});
        check("fips256_rk2",  {128'd0, cap[2]},  {128'd0, 128'h9ba354118e6925afa51a8b5f2067fcde});
        check("fips256_rk14", {128'd0, cap[14]}, {128'd0, 128'hfe4890d1e6188d0b046df344706c631e});

        // restart pulses ignored mid-run, then a back-to-back run
        run(rnd256(), 1'b0, 1'b1, 0, 0);
        run(rnd256(), 1'b1, 1'b1, 0, 0);
        run(rnd256(), 1'b1, 1'b0, 0, 0);

        run(rnd256(), 1'b1, 1'b0, 6, 0);
        run(rnd256(), 1'b1, 1'b0, 0, 0);

`ifdef KEYEXP_ABORT_EN
        run(rnd256(), 1'b0, 1'b0, 0, 7);
        run(rnd256(), 1'b1, 1'b0, 0, 0);
`endif

        for (int i = 0; i < 4; i++) run(rnd256(), 1'($urandom), 1'b0, 0, 0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
